// File: rtl/ctr_pkg.sv
// Shared encodings for the bounded up/down counter family: boundary modes and
// run-state machine states.
package ctr_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturate and one-shot stop at the bound; everything else (incl. 2'b11) wraps.
  function automatic logic is_clamping(input logic [1:0] mode);
    return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
  endfunction

  function automatic logic is_wrap(input logic [1:0] mode);
    return (mode == MODE_WRAP) || !is_clamping(mode);
  endfunction

endpackage

// File: rtl/ctr_prescaler.sv
// Tick generator: one tick every PRESCALE enabled clocks; clr restarts the
// period, and a deasserted en freezes it.
module ctr_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)
      pcnt <= '0;
    else if (en)
      pcnt <= tick ? '0 : pcnt + PW'(1);
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Up/down counter bounded by runtime min/max with wrap/saturate/one-shot modes,
// load, hold and terminal-count pulse. Define CNT_PRESCALE_EN to add a tick prescaler.
module bounded_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic             tick;
  logic             bad;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   lo_edge;
  logic [WIDTH-1:0] cnt_adv;
  logic             tc_adv;
  logic             hit;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

`ifdef CNT_PRESCALE_EN
  ctr_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start | stop | load),
    .en   ((state == ST_RUN) && !hold),
    .tick (tick)
  );
`else
  // Without the prescaler every RUN cycle is a tick.
  assign tick = (PRESCALE >= 1);
`endif

  assign bad     = (min_val > max_val);
  assign busy    = (state == ST_RUN);
  assign sum     = {1'b0, cnt} + {1'b0, step};
  // cnt - step < min  <=>  cnt < min + step, kept in WIDTH+1 bits to avoid underflow
  assign lo_edge = {1'b0, min_val} + {1'b0, step};

  always_comb begin
    cnt_adv = cnt;
    tc_adv  = 1'b0;
    hit     = 1'b0;
    if (hold || (step == '0) || bad) begin
      cnt_adv = cnt;
    end else if ((cnt < min_val) || (cnt > max_val)) begin
      cnt_adv = dir ? min_val : max_val;
    end else if (dir) begin
      if (is_wrap(mode)) begin
        if (sum > {1'b0, max_val}) begin
          cnt_adv = min_val;
          tc_adv  = 1'b1;
        end else begin
          cnt_adv = sum[WIDTH-1:0];
        end
      end else if (cnt != max_val) begin
        if (sum >= {1'b0, max_val}) begin
          cnt_adv = max_val;
          tc_adv  = 1'b1;
          hit     = 1'b1;
        end else begin
          cnt_adv = sum[WIDTH-1:0];
        end
      end
    end else begin
      if (is_wrap(mode)) begin
        if ({1'b0, cnt} < lo_edge) begin
          cnt_adv = max_val;
          tc_adv  = 1'b1;
        end else begin
          cnt_adv = cnt - step;
        end
      end else if (cnt != min_val) begin
        if ({1'b0, cnt} <= lo_edge) begin
          cnt_adv = min_val;
          tc_adv  = 1'b1;
          hit     = 1'b1;
        end else begin
          cnt_adv = cnt - step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      tc    <= 1'b0;
      err   <= 1'b0;
      state <= ST_IDLE;
    end else begin
      err <= bad;
      tc  <= 1'b0;
      if (load) begin
        cnt <= clamp(load_val, min_val, max_val);
      end else if (stop) begin
        state <= ST_IDLE;
      end else if (start) begin
        cnt   <= dir ? min_val : max_val;
        state <= ST_RUN;
      end else if ((state == ST_RUN) && tick) begin
        cnt <= cnt_adv;
        tc  <= tc_adv;
        if (hit && (mode == MODE_ONESHOT))
          state <= ST_DONE;
      end
    end
  end

endmodule
